keypad_scan: RTL

- Front-end stage for the digital watch: scans a 4-row x 3-column matrix keypad (1-9, *, 0, #), debounces it and drives the watch's 10-bit one-hot digit input (bit n = digit n, all-zero = no key).
- Runs on the same 1 kHz clock as the watch and sits directly between the board keypad pins and the watch keypad port.
- Also flags * and # for later mode and control use.

---
 rtl/keypad_scan_if.sv | 24 ++
 rtl/keypad_scan.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_if.sv
`default_nettype none
// ============================================================================
// keypad_scan_if : matrix keypad pins and debounced watch-side key outputs
// Revision 1.0
// ============================================================================
interface keypad_scan_if;
    logic [3:0] key_row;
    logic [2:0] key_col;
    logic [9:0] keypad;
    logic       key_star;
    logic       key_hash;
    logic       key_press;

    // master is the scanner; slave is the board/watch side around it
    modport master (
        input  key_row,
        output key_col, keypad, key_star, key_hash, key_press
    );
    modport slave (
        output key_row,
        input  key_col, keypad, key_star, key_hash, key_press
    );
endinterface
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
// keypad_scan : 4x3 matrix keypad scanner/debouncer driving one-hot digit keys
// Revision 1.0
// ============================================================================
module keypad_scan #(
    parameter int SCAN_TICKS = 2,
    parameter int DEB_SCANS  = 3
) (
    input  logic          clk,
    input  logic          rst,
    keypad_scan_if.master kp
);
    localparam int TICK_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int CNT_W  = $clog2(DEB_SCANS + 1);
    localparam logic [TICK_W-1:0] C_LAST_TICK = TICK_W'(SCAN_TICKS - 1);
    localparam logic [CNT_W-1:0]  C_CNT_MAX   = CNT_W'(DEB_SCANS);
    localparam logic [CNT_W-1:0]  C_CNT_ONE   = CNT_W'(1);
    localparam logic [3:0] C_STAR  = 4'd10;
    localparam logic [3:0] C_HASH  = 4'd11;
    localparam logic [3:0] C_NONE  = 4'd12;
    localparam logic [3:0] C_MULTI = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_PRESS_CHK   = 2'd1,
        S_PRESSED     = 2'd2,
        S_RELEASE_CHK = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        key_col_q, key_col_d;
    logic [1:0]        acc_hits_q, acc_hits_d;
    logic [3:0]        acc_code_q, acc_code_d;
    logic [3:0]        cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [9:0]        keypad_q, keypad_d;
    logic              key_star_q, key_star_d;
    logic              key_hash_q, key_hash_d;
    logic              key_press_q, key_press_d;

    logic       sample, frame_done, frame_single;
    logic [1:0] col_idx, row_idx, col_hits, sum_hits;
    logic [2:0] sum_hits_raw;
    logic [3:0] low_rows, col_code, sum_code, frame_code, accept_code;

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = C_STAR;
                2'd1:    code = 4'd0;
                default: code = C_HASH;
            endcase
        end else begin
            code = 4'(row) * 4'd3 + 4'(col) + 4'd1;
        end
        return code;
    endfunction

    function automatic logic [9:0] digit_onehot(input logic [3:0] code);
        logic [9:0] oh;
        oh = '0;
        for (int i = 0; i < 10; i++) begin
            if (code == 4'(i)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

    // Column scan and per-frame hit accumulation
    always_comb begin
        sample     = (tick_q == C_LAST_TICK);
        frame_done = sample && (key_col_q == 3'b011);
        case (key_col_q)
            3'b110:  col_idx = 2'd0;
            3'b101:  col_idx = 2'd1;
            default: col_idx = 2'd2;
        endcase

        low_rows = ~kp.key_row;
        row_idx  = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (low_rows[r]) row_idx = 2'(r);
        end
        if (low_rows == 4'd0)        col_hits = 2'd0;
        else if ($onehot(low_rows))  col_hits = 2'd1;
        else                         col_hits = 2'd2;
        col_code = key_code(row_idx, col_idx);

        sum_hits_raw = {1'b0, acc_hits_q} + {1'b0, col_hits};
        sum_hits     = (sum_hits_raw >= 3'd2) ? 2'd2 : sum_hits_raw[1:0];
        sum_code     = (acc_hits_q == 2'd0) ? col_code : acc_code_q;
        case (sum_hits)
            2'd0:    frame_code = C_NONE;
            2'd1:    frame_code = sum_code;
            default: frame_code = C_MULTI;
        endcase
        frame_single = (sum_hits == 2'd1);

        tick_d     = tick_q + TICK_W'(1);
        key_col_d  = key_col_q;
        acc_hits_d = acc_hits_q;
        acc_code_d = acc_code_q;
        if (sample) begin
            tick_d = '0;
            case (key_col_q)
                3'b110:  key_col_d = 3'b101;
                3'b101:  key_col_d = 3'b011;
                default: key_col_d = 3'b110;
            endcase
            if (frame_done) begin
                acc_hits_d = 2'd0;
                acc_code_d = 4'd0;
            end else begin
                acc_hits_d = sum_hits;
                acc_code_d = sum_code;
            end
        end
    end

    // Debounce FSM; only the frame_done edge moves it
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        keypad_d    = keypad_q;
        key_star_d  = key_star_q;
        key_hash_d  = key_hash_q;
        key_press_d = 1'b0;
        accept_code = (state_q == S_IDLE) ? frame_code : cand_q;

        if (frame_done) begin
            case (state_q)
                S_IDLE: begin
                    if (frame_single) begin
                        cand_d = frame_code;
                        cnt_d  = C_CNT_ONE;
                        if (DEB_SCANS == 1) begin
                            state_d     = S_PRESSED;
                            keypad_d    = digit_onehot(accept_code);
                            key_star_d  = (accept_code == C_STAR);
                            key_hash_d  = (accept_code == C_HASH);
                            key_press_d = 1'b1;
                        end else begin
                            state_d = S_PRESS_CHK;
                        end
                    end
                end
                S_PRESS_CHK: begin
                    if (frame_single && frame_code == cand_q) begin
                        if (cnt_q >= C_CNT_MAX - C_CNT_ONE) begin
                            state_d     = S_PRESSED;
                            cnt_d       = C_CNT_MAX;
                            keypad_d    = digit_onehot(accept_code);
                            key_star_d  = (accept_code == C_STAR);
                            key_hash_d  = (accept_code == C_HASH);
                            key_press_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + C_CNT_ONE;
                        end
                    end else if (frame_single) begin
                        cand_d = frame_code;
                        cnt_d  = C_CNT_ONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_PRESSED: begin
                    if (frame_code == C_NONE) begin
                        cnt_d = C_CNT_ONE;
                        if (DEB_SCANS == 1) begin
                            state_d    = S_IDLE;
                            keypad_d   = '0;
                            key_star_d = 1'b0;
                            key_hash_d = 1'b0;
                        end else begin
                            state_d = S_RELEASE_CHK;
                        end
                    end
                end
                S_RELEASE_CHK: begin
                    if (frame_code == C_NONE) begin
                        if (cnt_q >= C_CNT_MAX - C_CNT_ONE) begin
                            state_d    = S_IDLE;
                            cnt_d      = C_CNT_MAX;
                            keypad_d   = '0;
                            key_star_d = 1'b0;
                            key_hash_d = 1'b0;
                        end else begin
                            cnt_d = cnt_q + C_CNT_ONE;
                        end
                    end else begin
                        state_d = S_PRESSED;
                    end
                end
                default: begin
                    state_d    = S_IDLE;
                    keypad_d   = '0;
                    key_star_d = 1'b0;
                    key_hash_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            tick_q      <= '0;
            key_col_q   <= 3'b110;
            acc_hits_q  <= 2'd0;
            acc_code_q  <= 4'd0;
            cand_q      <= 4'd0;
            cnt_q       <= '0;
            keypad_q    <= '0;
            key_star_q  <= 1'b0;
            key_hash_q  <= 1'b0;
            key_press_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            key_col_q   <= key_col_d;
            acc_hits_q  <= acc_hits_d;
            acc_code_q  <= acc_code_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            keypad_q    <= keypad_d;
            key_star_q  <= key_star_d;
            key_hash_q  <= key_hash_d;
            key_press_q <= key_press_d;
        end
    end

    assign kp.key_col   = key_col_q;
    assign kp.keypad    = keypad_q;
    assign kp.key_star  = key_star_q;
    assign kp.key_hash  = key_hash_q;
    assign kp.key_press = key_press_q;
endmodule
`default_nettype wire
